// File: rtl/ksa_chunk_sequencer.sv
// Multi-cycle wide add/subtract sequencer: feeds one CW-bit adder stage chunk by
// chunk (LSB first), chains the carry, and presents the W-bit result via valid/ready.
module ksa_chunk_sequencer #(
    parameter int unsigned BW     = 16,
    parameter int unsigned NCHUNK = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NCHUNK*(BW-1)-1:0]     in_a,
    input  logic [NCHUNK*(BW-1)-1:0]     in_b,
    input  logic                         in_cin,
    input  logic                         in_sub,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NCHUNK*(BW-1)-1:0]     out_sum,
    output logic                         out_cout,
    output logic                         out_ovf,
    output logic [BW-2:0]                add_a,
    output logic [BW-2:0]                add_b,
    output logic                         add_cin,
    input  logic [BW-2:0]                add_sum,
    input  logic                         add_cout
);

    localparam int unsigned CW = BW - 1;
    localparam int unsigned W  = NCHUNK * CW;
    localparam int unsigned IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [W-1:0]    sum_reg;
    logic            carry;
    logic            mode_sub;
    logic [IW-1:0]   idx;
    logic            last;

    assign last     = (idx == IW'(NCHUNK - 1));
    assign in_ready = (state == IDLE);
    assign out_sum  = sum_reg;

    // The operand chunk and carry-in for the current step come straight from the
    // stored operands; the adder sees zeros whenever no chunk is in flight.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state == RUN) begin
            add_a   = a_reg[idx*CW +: CW];
            add_b   = b_reg[idx*CW +: CW];
            add_cin = carry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry     <= 1'b0;
            mode_sub  <= 1'b0;
            idx       <= '0;
            out_valid <= 1'b0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction is A + ~B + 1, so the inversion and the
                        // forced carry-in are applied once at capture time.
                        a_reg    <= in_a;
                        b_reg    <= in_sub ? ~in_b : in_b;
                        carry    <= in_sub ? 1'b1 : in_cin;
                        mode_sub <= in_sub;
                        idx      <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    sum_reg[idx*CW +: CW] <= add_sum;
                    carry                 <= add_cout;
                    idx                   <= idx + 1'b1;
                    if (last) begin
                        out_cout  <= add_cout;
                        out_ovf   <= a_reg[W-1] ^ b_reg[W-1] ^ add_sum[CW-1] ^ add_cout;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        mode_sub  <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
